// File: rtl/wavelet_pe_feeder_ctrl_if.sv
// Control/handshake bundle between the wavelet PE feeder sequencer, the
// decomposition-level controller (start/config) and the feeder/PE pair.
interface wavelet_pe_feeder_ctrl_if #(
  parameter int FS_WIDTH        = 4,
  parameter int OUT_COUNT_WIDTH = 11
);
  logic                       start;
  logic                       downsample;
  logic [1:0]                 cur_dec_level;
  logic [FS_WIDTH-1:0]        filter_size;
  logic [OUT_COUNT_WIDTH-1:0] out_count;
  logic                       pe_ready;
  logic                       ibuff_data_ready;

  logic                       init_in_progress;
  logic                       pe_init;
  logic                       ibuff_r_addr_offset_rst;
  logic                       ibuff_r_addr_offset_upcount;
  logic                       ibuff_r_addr_offset_cen;
  logic                       ibuff_r_addr_base_reg_rst;
  logic                       feed_valid;
  logic                       feed_last;
  logic                       busy;
  logic                       done;

  modport master (
    input  start, downsample, cur_dec_level, filter_size, out_count,
           pe_ready, ibuff_data_ready,
    output init_in_progress, pe_init, ibuff_r_addr_offset_rst,
           ibuff_r_addr_offset_upcount, ibuff_r_addr_offset_cen,
           ibuff_r_addr_base_reg_rst, feed_valid, feed_last, busy, done
  );

  modport slave (
    output start, downsample, cur_dec_level, filter_size, out_count,
           pe_ready, ibuff_data_ready,
    input  init_in_progress, pe_init, ibuff_r_addr_offset_rst,
           ibuff_r_addr_offset_upcount, ibuff_r_addr_offset_cen,
           ibuff_r_addr_base_reg_rst, feed_valid, feed_last, busy, done
  );
endinterface

// File: rtl/wavelet_pe_feeder_ctrl.sv
// Sequencer for the wavelet PE input-buffer read path: one priming pass, then
// one tap burst per output sample, stalling on PE and input-buffer readiness.
module wavelet_pe_feeder_ctrl #(
  parameter int MAX_FILTER_SIZE = 16,
  parameter int FS_WIDTH        = $clog2(MAX_FILTER_SIZE-1),
  parameter int OUT_COUNT_WIDTH = 11,
  parameter int TAP_WIDTH       = FS_WIDTH+4
) (
  input  logic                      clk,
  input  logic                      rst,
  wavelet_pe_feeder_ctrl_if.master  bus
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_INIT_RST  = 3'd1;
  localparam logic [2:0] S_INIT_FEED = 3'd2;
  localparam logic [2:0] S_OUT_RST   = 3'd3;
  localparam logic [2:0] S_FEED      = 3'd4;
  localparam logic [2:0] S_ADV       = 3'd5;
  localparam logic [2:0] S_DONE      = 3'd6;

  function automatic logic [TAP_WIDTH-1:0] init_taps_f(input logic [FS_WIDTH-1:0] fs);
    init_taps_f = (TAP_WIDTH'(fs) << 1) + TAP_WIDTH'(2);
  endfunction

  // A zero-length burst would never reach its last beat, so it is promoted to one tap.
  function automatic logic [TAP_WIDTH-1:0] feed_taps_f(input logic ds,
                                                       input logic [1:0] lvl,
                                                       input logic [FS_WIDTH-1:0] fs);
    logic [TAP_WIDTH-1:0] t;
    t = ds ? TAP_WIDTH'(fs) : (TAP_WIDTH'(fs) << lvl);
    if (t == {TAP_WIDTH{1'b0}}) begin
      t = TAP_WIDTH'(1);
    end else begin
      t = t;
    end
    feed_taps_f = t;
  endfunction

  logic [2:0]                 state_r;
  logic                       ds_r;
  logic [1:0]                 lvl_r;
  logic [FS_WIDTH-1:0]        fs_r;
  logic [OUT_COUNT_WIDTH-1:0] oc_r;
  logic [TAP_WIDTH-1:0]       tap_cnt_r;
  logic [OUT_COUNT_WIDTH-1:0] out_cnt_r;

  logic [2:0]                 state_next_s;
  logic [TAP_WIDTH-1:0]       tap_next_s;
  logic [OUT_COUNT_WIDTH-1:0] out_next_s;
  logic                       cfg_load_s;
  logic                       beat_s;
  logic [TAP_WIDTH-1:0]       cur_taps_s;
  logic [TAP_WIDTH-1:0]       tap_inc_s;
  logic [OUT_COUNT_WIDTH-1:0] out_inc_s;
  logic                       last_tap_s;

  assign beat_s     = bus.pe_ready & bus.ibuff_data_ready;
  assign cur_taps_s = (state_r == S_INIT_FEED) ? init_taps_f(fs_r)
                                               : feed_taps_f(ds_r, lvl_r, fs_r);
  assign tap_inc_s  = tap_cnt_r + TAP_WIDTH'(1);
  assign out_inc_s  = out_cnt_r + OUT_COUNT_WIDTH'(1);
  assign last_tap_s = (tap_inc_s == cur_taps_s);

  // Next-state, tap-counter and output-counter decode.
  always_comb begin
    state_next_s = state_r;
    tap_next_s   = tap_cnt_r;
    out_next_s   = out_cnt_r;
    cfg_load_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (bus.start) begin
          cfg_load_s = 1'b1;
          out_next_s = {OUT_COUNT_WIDTH{1'b0}};
          tap_next_s = {TAP_WIDTH{1'b0}};
          state_next_s = (bus.out_count == {OUT_COUNT_WIDTH{1'b0}}) ? S_DONE : S_INIT_RST;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_INIT_RST: begin
        tap_next_s   = {TAP_WIDTH{1'b0}};
        state_next_s = S_INIT_FEED;
      end
      S_INIT_FEED, S_FEED: begin
        if (beat_s) begin
          tap_next_s = tap_inc_s;
          if (last_tap_s) begin
            state_next_s = (state_r == S_INIT_FEED) ? S_OUT_RST : S_ADV;
          end else begin
            state_next_s = state_r;
          end
        end else begin
          state_next_s = state_r;
        end
      end
      S_OUT_RST: begin
        tap_next_s   = {TAP_WIDTH{1'b0}};
        state_next_s = S_FEED;
      end
      S_ADV: begin
        tap_next_s = {TAP_WIDTH{1'b0}};
        out_next_s = out_inc_s;
        if (out_inc_s == oc_r) begin
          state_next_s = S_DONE;
        end else begin
          state_next_s = S_FEED;
        end
      end
      S_DONE: begin
        state_next_s = S_IDLE;
      end
      default: begin
        state_next_s = S_IDLE;
      end
    endcase
  end

  // State, counters and latched configuration.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= S_IDLE;
      tap_cnt_r <= {TAP_WIDTH{1'b0}};
      out_cnt_r <= {OUT_COUNT_WIDTH{1'b0}};
      ds_r      <= 1'b0;
      lvl_r     <= 2'b00;
      fs_r      <= {FS_WIDTH{1'b0}};
      oc_r      <= {OUT_COUNT_WIDTH{1'b0}};
    end else begin
      state_r   <= state_next_s;
      tap_cnt_r <= tap_next_s;
      out_cnt_r <= out_next_s;
      if (cfg_load_s) begin
        ds_r  <= bus.downsample;
        lvl_r <= bus.cur_dec_level;
        fs_r  <= bus.filter_size;
        oc_r  <= bus.out_count;
      end else begin
        ds_r  <= ds_r;
        lvl_r <= lvl_r;
        fs_r  <= fs_r;
        oc_r  <= oc_r;
      end
    end
  end

  logic init_s, pe_init_s, orst_s, up_s, cen_s, brst_s, last_s, busy_s, done_s;

  // Feeder controls are Moore outputs of state, gated by the beat condition in burst states.
  always_comb begin
    init_s    = 1'b0;
    pe_init_s = 1'b0;
    orst_s    = 1'b0;
    up_s      = 1'b0;
    cen_s     = 1'b0;
    brst_s    = 1'b0;
    last_s    = 1'b0;
    busy_s    = 1'b0;
    done_s    = 1'b0;
    case (state_r)
      S_IDLE: begin
        busy_s = 1'b0;
      end
      S_INIT_RST: begin
        init_s    = 1'b1;
        pe_init_s = 1'b1;
        orst_s    = 1'b1;
        brst_s    = 1'b1;
        up_s      = 1'b1;
        busy_s    = 1'b1;
      end
      S_INIT_FEED, S_FEED: begin
        init_s = (state_r == S_INIT_FEED);
        up_s   = 1'b1;
        busy_s = 1'b1;
        cen_s  = beat_s;
        last_s = beat_s & last_tap_s;
      end
      S_OUT_RST: begin
        orst_s = 1'b1;
        brst_s = 1'b1;
        up_s   = 1'b1;
        busy_s = 1'b1;
      end
      S_ADV: begin
        orst_s = 1'b1;
        up_s   = 1'b1;
        busy_s = 1'b1;
      end
      S_DONE: begin
        done_s = 1'b1;
        busy_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  assign bus.init_in_progress            = init_s;
  assign bus.pe_init                     = pe_init_s;
  assign bus.ibuff_r_addr_offset_rst     = orst_s;
  assign bus.ibuff_r_addr_offset_upcount = up_s;
  assign bus.ibuff_r_addr_offset_cen     = cen_s;
  assign bus.ibuff_r_addr_base_reg_rst   = brst_s;
  assign bus.feed_valid                  = cen_s;
  assign bus.feed_last                   = last_s;
  assign bus.busy                        = busy_s;
  assign bus.done                        = done_s;

endmodule

// File: tb/tb_wavelet_pe_feeder_ctrl.sv
// Directed bench for wavelet_pe_feeder_ctrl: a segment-queue model of the
// expected sequence is checked every cycle, plus hand-computed totals.
module tb_wavelet_pe_feeder_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wavelet_pe_feeder_ctrl_if #(.FS_WIDTH(4), .OUT_COUNT_WIDTH(11)) bus ();

  wavelet_pe_feeder_ctrl #(.MAX_FILTER_SIZE(16), .OUT_COUNT_WIDTH(11)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  localparam int K_INIT_RST  = 0;
  localparam int K_INIT_FEED = 1;
  localparam int K_OUT_RST   = 2;
  localparam int K_FEED      = 3;
  localparam int K_ADV       = 4;
  localparam int K_DONE      = 5;

  typedef struct {int kind; int len;} seg_t;
  seg_t q[$];
  int   pos = 0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int start_cyc = 0;
  int cen_cnt = 0;
  int lasts[$];
  bit done_seen = 1'b0;
  int done_delta = -1;

  // The whole operation is a fixed list of segments; burst segments consume one entry per beat.
  task automatic build_model(input int ds, input int lvl, input int fs, input int oc);
    int taps;
    q.delete();
    pos = 0;
    if (oc == 0) begin
      q.push_back('{K_DONE, 1});
    end else begin
      taps = (ds != 0) ? fs : fs * (1 << lvl);
      if (taps == 0) taps = 1;
      q.push_back('{K_INIT_RST, 1});
      q.push_back('{K_INIT_FEED, 2 * fs + 2});
      q.push_back('{K_OUT_RST, 1});
      for (int o = 0; o < oc; o++) begin
        q.push_back('{K_FEED, taps});
        q.push_back('{K_ADV, 1});
      end
      q.push_back('{K_DONE, 1});
    end
  endtask

  // bit order: busy done init pe_init offset_rst upcount cen base_rst valid last
  function automatic logic [9:0] model_out(input bit beat);
    bit fl;
    if (q.size() == 0) return 10'b0;
    fl = beat && (pos + 1 == q[0].len);
    case (q[0].kind)
      K_INIT_RST:  return 10'b1011110100;
      K_INIT_FEED: return {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, beat, 1'b0, beat, fl};
      K_OUT_RST:   return 10'b1000110100;
      K_FEED:      return {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, beat, 1'b0, beat, fl};
      K_ADV:       return 10'b1000110000;
      K_DONE:      return 10'b1100000000;
      default:     return 10'b0;
    endcase
  endfunction

  always @(negedge clk) begin : compare
    bit beat;
    logic [9:0] exp_v, act_v;
    beat  = (bus.pe_ready === 1'b1) && (bus.ibuff_data_ready === 1'b1);
    exp_v = model_out(beat);
    act_v = {bus.busy, bus.done, bus.init_in_progress, bus.pe_init,
             bus.ibuff_r_addr_offset_rst, bus.ibuff_r_addr_offset_upcount,
             bus.ibuff_r_addr_offset_cen, bus.ibuff_r_addr_base_reg_rst,
             bus.feed_valid, bus.feed_last};
    total++;
    if (act_v !== exp_v) begin
      bad++;
      $display("FAIL outputs cycle=%0d actual=%b required=%b", cyc, act_v, exp_v);
    end
    if (bus.ibuff_r_addr_offset_cen === 1'b1) begin
      cen_cnt++;
      if (bus.feed_last === 1'b1) lasts.push_back(cen_cnt);
    end
    if (bus.done === 1'b1 && !done_seen) begin
      done_seen  = 1'b1;
      done_delta = cyc - start_cyc;
    end
    if (rst) begin
      q.delete();
      pos = 0;
    end else if (q.size() == 0) begin
      if (bus.start === 1'b1) begin
        start_cyc = cyc;
        build_model(int'(bus.downsample), int'(bus.cur_dec_level),
                    int'(bus.filter_size), int'(bus.out_count));
      end
    end else if (q[0].kind == K_INIT_FEED || q[0].kind == K_FEED) begin
      if (beat) begin
        pos++;
        if (pos == q[0].len) begin
          void'(q.pop_front());
          pos = 0;
        end
      end
    end else begin
      void'(q.pop_front());
    end
    cyc++;
  end

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic ds, input logic [1:0] lvl,
                          input logic [3:0] fs, input logic [10:0] oc);
    cen_cnt = 0;
    lasts.delete();
    done_seen = 1'b0;
    done_delta = -1;
    bus.downsample    = ds;
    bus.cur_dec_level = lvl;
    bus.filter_size   = fs;
    bus.out_count     = oc;
    bus.start         = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (!done_seen && n < budget) begin
      step();
      n++;
    end
    chk({name, "_done_reached"}, int'(done_seen), 1);
    step();
  endtask

  task automatic chk_last(input string name, input int idx, input int req);
    chk(name, (lasts.size() > idx) ? lasts[idx] : -1, req);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.downsample = 1'b0;
    bus.cur_dec_level = 2'd0;
    bus.filter_size = 4'd0;
    bus.out_count = 11'd0;
    bus.pe_ready = 1'b1;
    bus.ibuff_data_ready = 1'b1;

    // 1: reset then idle
    repeat (3) step();
    rst = 1'b0;
    cen_cnt = 0;
    repeat (20) step();
    chk("idle_cen", cen_cnt, 0);
    chk("idle_busy", int'(bus.busy), 0);

    // 2: fs=4 ds=1 oc=3: init 10 beats, 3 bursts of 4
    do_start(1'b1, 2'd0, 4'd4, 11'd3);
    wait_done("t2", 200);
    chk("t2_cen", cen_cnt, 22);
    // start cycle counted as 0: 1 INIT_RST + 10 init + 1 OUT_RST + 3*(4+1) -> DONE at 28
    chk("t2_done_cycle", done_delta, 28);
    chk("t2_nlast", lasts.size(), 4);
    chk_last("t2_last0", 0, 10);
    chk_last("t2_last1", 1, 14);
    chk_last("t2_last2", 2, 18);
    chk_last("t2_last3", 3, 22);

    // 3: fs=3 ds=0 lvl=2 oc=2 -> init 8, bursts of 12
    do_start(1'b0, 2'd2, 4'd3, 11'd2);
    wait_done("t3", 200);
    chk("t3_cen", cen_cnt, 32);
    chk_last("t3_last1", 1, 20);
    chk_last("t3_last2", 2, 32);

    // 4: stalls: pe_ready toggles, ibuff_data_ready low 5 cycles mid-burst
    do_start(1'b1, 2'd0, 4'd5, 11'd2);
    for (int i = 0; i < 300 && !done_seen; i++) begin
      bus.pe_ready = (i % 2 == 0);
      bus.ibuff_data_ready = !(i >= 30 && i < 35);
      step();
    end
    bus.pe_ready = 1'b1;
    bus.ibuff_data_ready = 1'b1;
    chk("t4_done_reached", int'(done_seen), 1);
    step();
    chk("t4_cen", cen_cnt, 22);
    chk_last("t4_last0", 0, 12);
    chk_last("t4_last1", 1, 17);
    chk_last("t4_last2", 2, 22);

    // 5a: out_count=0 -> DONE next cycle, no beats
    do_start(1'b1, 2'd0, 4'd4, 11'd0);
    wait_done("t5a", 10);
    chk("t5a_done_cycle", done_delta, 1);
    chk("t5a_cen", cen_cnt, 0);

    // 5b: start pulsed during FEED with different config is ignored
    do_start(1'b1, 2'd0, 4'd2, 11'd2);
    repeat (9) step();
    bus.filter_size = 4'd7;
    bus.out_count = 11'd0;
    bus.downsample = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_done("t5b", 100);
    chk("t5b_cen", cen_cnt, 10);
    chk_last("t5b_last2", 2, 10);

    // 5c: filter_size=0 burst is promoted to one tap
    do_start(1'b1, 2'd0, 4'd0, 11'd1);
    wait_done("t5c", 50);
    chk("t5c_cen", cen_cnt, 3);

    // 6: reset in FEED of output 2, then full replay
    do_start(1'b0, 2'd1, 4'd2, 11'd3);
    for (int i = 0; i < 200 && lasts.size() < 2; i++) step();
    repeat (2) step();
    rst = 1'b1;
    step();
    chk("t6_rst_busy", int'(bus.busy), 0);
    chk("t6_rst_cen", int'(bus.ibuff_r_addr_offset_cen), 0);
    rst = 1'b0;
    step();
    do_start(1'b0, 2'd1, 4'd2, 11'd3);
    wait_done("t6", 200);
    chk("t6_cen", cen_cnt, 18);
    chk_last("t6_last0", 0, 6);

    repeat (2) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
